// File: rtl/idct_pkg.sv
// Shared constants and types for the sequential 8x8 inverse DCT.
package idct_pkg;

  localparam int unsigned W         = 16;
  localparam int unsigned COEF_FRAC = 14;
  localparam int unsigned ACC_W     = 35;

  typedef logic signed [15:0] coef_t;

  // COEF[n][k] = round(16384 * c(k)/2 * cos((2n+1)k*pi/16)); n = spatial sample, k = frequency.
  localparam coef_t COEF [8][8] = '{
    '{16'sd5793,  16'sd8035,  16'sd7568,  16'sd6811,  16'sd5793,  16'sd4551,  16'sd3135,  16'sd1598},
    '{16'sd5793,  16'sd6811,  16'sd3135, -16'sd1598, -16'sd5793, -16'sd8035, -16'sd7568, -16'sd4551},
    '{16'sd5793,  16'sd4551, -16'sd3135, -16'sd8035, -16'sd5793,  16'sd1598,  16'sd7568,  16'sd6811},
    '{16'sd5793,  16'sd1598, -16'sd7568, -16'sd4551,  16'sd5793,  16'sd6811, -16'sd3135, -16'sd8035},
    '{16'sd5793, -16'sd1598, -16'sd7568,  16'sd4551,  16'sd5793, -16'sd6811, -16'sd3135,  16'sd8035},
    '{16'sd5793, -16'sd4551, -16'sd3135,  16'sd8035, -16'sd5793, -16'sd1598,  16'sd7568, -16'sd6811},
    '{16'sd5793, -16'sd6811,  16'sd3135,  16'sd1598, -16'sd5793,  16'sd8035, -16'sd7568,  16'sd4551},
    '{16'sd5793, -16'sd8035,  16'sd7568, -16'sd6811,  16'sd5793, -16'sd4551,  16'sd3135, -16'sd1598}
  };

  typedef enum logic [0:0] {LOAD, OUT} state_e;

endpackage

// File: rtl/idct_1d.sv
// Combinational 8-point IDCT with round-to-nearest and per-lane saturation.
module idct_1d
  import idct_pkg::*;
(
  input  logic [8*W-1:0] freq,
  output logic [8*W-1:0] spat,
  output logic [7:0]     sat
);

  // Half-LSB of the Q1.14 result, folded into the accumulator start value.
  localparam logic signed [ACC_W-1:0] RND =
    {{(ACC_W-COEF_FRAC){1'b0}}, 1'b1, {(COEF_FRAC-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] SAT_HI = {{(ACC_W-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_LO = ~SAT_HI;

  logic signed [ACC_W-1:0] acc [8];
  logic signed [ACC_W-1:0] shd [8];

  // Multiply-accumulate each output lane, round, shift and clamp.
  always_comb begin
    spat = '0;
    sat  = '0;
    for (int n = 0; n < 8; n++) begin
      acc[n] = RND;
      for (int k = 0; k < 8; k++) begin
        acc[n] = acc[n] + ACC_W'(signed'(freq[W*k +: W])) * ACC_W'(COEF[n][k]);
      end
      shd[n] = acc[n] >>> COEF_FRAC;
      if (shd[n] > SAT_HI) begin
        spat[W*n +: W] = SAT_HI[W-1:0];
        sat[n]         = 1'b1;
      end else if (shd[n] < SAT_LO) begin
        spat[W*n +: W] = SAT_LO[W-1:0];
        sat[n]         = 1'b1;
      end else begin
        spat[W*n +: W] = shd[n][W-1:0];
      end
    end
  end

endmodule

// File: rtl/idct_2d_seq.sv
// Sequential 8x8 2D IDCT: row pass into a transpose buffer, then column pass out.
module idct_2d_seq
  import idct_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [8*W-1:0] in_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [8*W-1:0] out_data,
  output logic           ovf
);

  state_e         state_q, state_d;
  logic [2:0]     row_q, row_d;
  logic [2:0]     col_q, col_d;
  logic           flag_q, flag_d;
  logic           row_we;
  logic [W-1:0]   tbuf_q [8][8];
  logic [8*W-1:0] col_vec;
  logic [8*W-1:0] idct_in;
  logic [8*W-1:0] spat;
  logic [7:0]     sat;

  // Gather buffer column col_q and select the shared transform's operand.
  always_comb begin
    col_vec = '0;
    for (int u = 0; u < 8; u++) begin
      col_vec[W*u +: W] = tbuf_q[u][col_q];
    end
    idct_in = (state_q == LOAD) ? in_data : col_vec;
  end

  idct_1d u_idct_1d (
    .freq (idct_in),
    .spat (spat),
    .sat  (sat)
  );

  // Next-state, counters, sticky saturation flag and handshake outputs.
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    flag_d    = flag_q;
    row_we    = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          row_we = 1'b1;
          row_d  = row_q + 3'd1;
          if (|sat) flag_d = 1'b1;
          if (row_q == 3'd7) begin
            state_d = OUT;
            row_d   = '0;
          end
        end
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          col_d = col_q + 3'd1;
          if (|sat) flag_d = 1'b1;
          if (col_q == 3'd7) begin
            state_d = LOAD;
            col_d   = '0;
            flag_d  = 1'b0;
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

  // Drive data only while presenting a column; ovf includes the final beat's own clamp.
  always_comb begin
    out_data = (state_q == OUT) ? spat : '0;
    ovf      = (state_q == OUT) && (col_q == 3'd7) && (flag_q || (|sat));
  end

  // Control state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LOAD;
      row_q   <= '0;
      col_q   <= '0;
      flag_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      flag_q  <= flag_d;
    end
  end

  // Transpose buffer: each accepted row's row-pass result lands in buffer row row_q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        for (int j = 0; j < 8; j++) begin
          tbuf_q[i][j] <= '0;
        end
      end
    end else if (row_we) begin
      for (int n = 0; n < 8; n++) begin
        tbuf_q[row_q][n] <= spat[W*n +: W];
      end
    end
  end

endmodule

// File: tb/tb_idct_2d_seq.sv
// Directed and randomized checks for the sequential 8x8 IDCT.
`timescale 1ns/1ps
module tb_idct_2d_seq;
  import idct_pkg::*;

  localparam int NB = 200;
  localparam real PI = 3.14159265358979323846;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [8*W-1:0] in_data = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [8*W-1:0] out_data;
  logic           ovf;

  int  vectors = 0;
  int  miscompares = 0;
  int  coef [NB][8][8];
  real basis [8][8];

  idct_2d_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  function automatic logic [8*W-1:0] splat(input int val);
    logic [8*W-1:0] r;
    for (int i = 0; i < 8; i++) r[W*i +: W] = W'(val);
    return r;
  endfunction

  // Present one row and hold it until accepted (bounded); returns at posedge+1.
  task automatic put_row(input logic [8*W-1:0] d);
    int t;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    t = 0;
    #1;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (!in_ready) begin
      miscompares++;
      $display("FAIL put_row timeout: in_ready=%b want 1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Accept one output beat (bounded wait); returns at posedge+1.
  task automatic take_beat(output logic [8*W-1:0] d, output logic o, output bit ok);
    int t;
    @(negedge clk);
    out_ready = 1'b1;
    t = 0;
    #1;
    while (!out_valid && t < 50) begin
      @(negedge clk);
      #1;
      t++;
    end
    ok = out_valid;
    d  = out_data;
    o  = ovf;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    vectors++;
    if ({in_ready, out_valid, ovf} !== 3'b100) begin
      miscompares++;
      $display("FAIL reset_hs: got rdy/vld/ovf=%b want 100", {in_ready, out_valid, ovf});
    end
    vectors++;
    if (out_data !== '0) begin
      miscompares++;
      $display("FAIL reset_data: got %h want 0", out_data);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    vectors++;
    if ({in_ready, out_valid, ovf} !== 3'b100 || out_data !== '0) begin
      miscompares++;
      $display("FAIL post_reset: got rdy/vld/ovf=%b data=%h want 100/0",
               {in_ready, out_valid, ovf}, out_data);
    end
  endtask

  task automatic test_dc();
    logic [8*W-1:0] row0, d;
    logic o;
    bit ok;
    row0 = '0;
    row0[W-1:0] = W'(64);
    put_row(row0);
    for (int r = 1; r < 7; r++) put_row('0);
    @(negedge clk);
    #1;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL dc_before_row7: got vld=%b rdy=%b want 0/1", out_valid, in_ready);
    end
    put_row('0);
    vectors++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL dc_latency: got vld=%b rdy=%b want 1/0", out_valid, in_ready);
    end
    for (int b = 0; b < 8; b++) begin
      take_beat(d, o, ok);
      vectors++;
      if (!ok || d !== splat(8) || o !== 1'b0) begin
        miscompares++;
        $display("FAIL dc_beat%0d: got ok=%0d data=%h ovf=%b want data=%h ovf=0",
                 b, ok, d, o, splat(8));
      end
    end
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL dc_return: got rdy=%b vld=%b want 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_zero();
    logic [8*W-1:0] d;
    logic o;
    bit ok;
    for (int r = 0; r < 8; r++) put_row('0);
    for (int b = 0; b < 8; b++) begin
      take_beat(d, o, ok);
      vectors++;
      if (!ok || d !== '0 || o !== 1'b0) begin
        miscompares++;
        $display("FAIL zero_beat%0d: got ok=%0d data=%h ovf=%b want 0/0", b, ok, d, o);
      end
    end
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL zero_return: got rdy=%b want 1", in_ready);
    end
  endtask

  task automatic test_backpressure();
    logic [8*W-1:0] row0;
    int hs, cyc;
    row0 = '0;
    row0[W-1:0] = W'(64);
    put_row(row0);
    for (int r = 1; r < 8; r++) put_row('0);
    hs = 0;
    cyc = 0;
    while (hs < 8 && cyc < 64) begin
      @(negedge clk);
      out_ready = cyc[0];
      #1;
      vectors++;
      if (out_valid !== 1'b1 || out_data !== splat(8) || in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL bp_cycle%0d: got vld=%b rdy=%b data=%h want 1/0/%h",
                 cyc, out_valid, in_ready, out_data, splat(8));
      end
      if (out_valid && out_ready) hs++;
      cyc++;
    end
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    vectors++;
    if (hs != 8 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_end: got hs=%0d rdy=%b vld=%b want 8/1/0", hs, in_ready, out_valid);
    end
  endtask

  task automatic test_saturation();
    logic [8*W-1:0] d;
    logic o;
    bit ok;
    put_row(splat(32767));
    for (int r = 1; r < 8; r++) put_row('0);
    for (int b = 0; b < 8; b++) begin
      take_beat(d, o, ok);
      vectors++;
      if (!ok || o !== (b == 7)) begin
        miscompares++;
        $display("FAIL sat_ovf%0d: got ok=%0d ovf=%b want %b", b, ok, o, (b == 7));
      end
      if (b == 0) begin
        vectors++;
        if (d !== splat(11586)) begin
          miscompares++;
          $display("FAIL sat_beat0: got %h want %h", d, splat(11586));
        end
      end
      if (b == 7) begin
        vectors++;
        if (d !== splat(915)) begin
          miscompares++;
          $display("FAIL sat_beat7: got %h want %h", d, splat(915));
        end
      end
    end
  endtask

  task automatic test_reset_midload();
    logic [8*W-1:0] row0, d;
    logic o;
    bit ok;
    for (int r = 0; r < 3; r++) put_row(splat(1000 + r));
    @(negedge clk);
    rst = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL midload_reset: got rdy=%b vld=%b want 1/0", in_ready, out_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    row0 = '0;
    row0[W-1:0] = W'(64);
    put_row(row0);
    for (int r = 1; r < 8; r++) put_row('0);
    // Garbage rows offered while the block is emitting must be ignored.
    in_valid = 1'b1;
    in_data  = splat(1234);
    for (int b = 0; b < 8; b++) begin
      take_beat(d, o, ok);
      in_valid = (b != 7);
      vectors++;
      if (!ok || d !== splat(8)) begin
        miscompares++;
        $display("FAIL midload_beat%0d: got ok=%0d data=%h want %h", b, ok, d, splat(8));
      end
    end
    for (int r = 0; r < 8; r++) put_row('0);
    for (int b = 0; b < 8; b++) begin
      take_beat(d, o, ok);
      vectors++;
      if (!ok || d !== '0) begin
        miscompares++;
        $display("FAIL ignore_beat%0d: got ok=%0d data=%h want 0", b, ok, d);
      end
    end
  endtask

  task automatic test_random();
    int pb, pr, cb, cc, cyc, g, bad_lane, bad_got;
    real mdl, bad_mdl, diff;
    for (int b = 0; b < NB; b++)
      for (int u = 0; u < 8; u++)
        for (int v = 0; v < 8; v++)
          coef[b][u][v] = int'($urandom_range(0, 2047)) - 1024;
    pb = 0; pr = 0; cb = 0; cc = 0; cyc = 0;
    while (cb < NB && cyc < 40000) begin
      @(negedge clk);
      in_valid = (pb < NB) && ($urandom_range(0, 3) != 0);
      if (pb < NB) for (int v = 0; v < 8; v++) in_data[W*v +: W] = W'(coef[pb][pr][v]);
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (in_valid && in_ready) begin
        pr++;
        if (pr == 8) begin
          pr = 0;
          pb++;
        end
      end
      if (out_valid && out_ready) begin
        vectors++;
        if (cb >= pb) begin
          miscompares++;
          $display("FAIL rand_extra_beat: got beat for block %0d want none (loaded %0d)", cb, pb);
        end else begin
          bad_lane = -1;
          bad_got = 0;
          bad_mdl = 0.0;
          for (int m = 0; m < 8; m++) begin
            mdl = 0.0;
            for (int u = 0; u < 8; u++)
              for (int v = 0; v < 8; v++)
                mdl += real'(coef[cb][u][v]) * basis[m][u] * basis[cc][v];
            g = int'($signed(out_data[W*m +: W]));
            diff = real'(g) - mdl;
            if ((diff > 2.0 || diff < -2.0) && bad_lane < 0) begin
              bad_lane = m;
              bad_got = g;
              bad_mdl = mdl;
            end
          end
          if (bad_lane >= 0) begin
            miscompares++;
            $display("FAIL rand_blk%0d_col%0d lane%0d: got %0d want %f +-2",
                     cb, cc, bad_lane, bad_got, bad_mdl);
          end
        end
        cc++;
        if (cc == 8) begin
          cc = 0;
          cb++;
        end
      end
      cyc++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    vectors++;
    if (cb != NB || pb != NB) begin
      miscompares++;
      $display("FAIL rand_timeout: got %0d blocks out %0d in want %0d", cb, pb, NB);
    end
  endtask

  initial begin
    for (int n = 0; n < 8; n++)
      for (int k = 0; k < 8; k++)
        basis[n][k] = ((k == 0) ? (1.0 / $sqrt(2.0)) : 1.0) / 2.0
                      * $cos(real'((2 * n + 1) * k) * PI / 16.0);
    test_reset();
    test_dc();
    test_zero();
    test_backpressure();
    test_saturation();
    test_reset_midload();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
